// File: rtl/count4_stage_pkg.sv
// Shared constants for the count4_stage counter slice.
package count4_stage_pkg;
  localparam int unsigned COUNT_W           = 4;
  localparam int unsigned MOD_DEFAULT       = 16;
  localparam int unsigned RESET_VAL_DEFAULT = 0;
endpackage

// File: rtl/dff4_ar.sv
// 4-bit D register with asynchronous active-high reset to RST_VAL.
module dff4_ar
  import count4_stage_pkg::*;
#(
  parameter logic [COUNT_W-1:0] RST_VAL = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [COUNT_W-1:0] d_i,
  output logic [COUNT_W-1:0] q_o
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) q_o <= RST_VAL;
    else     q_o <= d_i;
  end
endmodule

// File: rtl/incrementer4bit.sv
// Combinational 4-bit +1 incrementer; s_o[4] is the carry out of the top bit.
module incrementer4bit (
  input  logic [3:0] a_i,
  output logic [4:0] s_o
);
  assign s_o = {1'b0, a_i} + 5'd1;
endmodule

// File: rtl/count4_stage.sv
// Registered 4-bit counter stage with load, programmable terminal count,
// wrap/saturate mode, cascade carry and sticky overflow.
module count4_stage
  import count4_stage_pkg::*;
#(
  parameter int unsigned MOD       = MOD_DEFAULT,
  parameter int unsigned RESET_VAL = RESET_VAL_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               load,
  input  logic [COUNT_W-1:0] din,
  input  logic               sat_mode,
  input  logic               clr_ovf,
  output logic [COUNT_W-1:0] q,
  output logic               tc,
  output logic               carry_out,
  output logic               ovf
);
  localparam logic [COUNT_W-1:0] TERM = COUNT_W'(MOD - 1);

  logic [COUNT_W-1:0] count_q, count_d;
  logic [COUNT_W:0]   sum;
  logic               ovf_q, ovf_d, ovf_set;

  incrementer4bit u_inc (
    .a_i (count_q),
    .s_o (sum)
  );

  dff4_ar #(.RST_VAL(COUNT_W'(RESET_VAL))) u_cnt (
    .clk (clk),
    .rst (rst),
    .d_i (count_d),
    .q_o (count_q)
  );

  assign tc        = (count_q == TERM);
  assign carry_out = en & tc;

  // Top-of-range is either the terminal count or the incrementer carry
  // (the latter only reachable after an out-of-range load).
  always_comb begin
    count_d = count_q;
    ovf_set = 1'b0;
    if (load) begin
      count_d = din;
    end else if (en) begin
      if (tc || sum[COUNT_W]) begin
        ovf_set = 1'b1;
        count_d = sat_mode ? count_q : '0;
      end else begin
        count_d = sum[COUNT_W-1:0];
      end
    end
    ovf_d = ovf_set | (ovf_q & ~clr_ovf);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end

  assign q   = count_q;
  assign ovf = ovf_q;
endmodule

// File: tb/tb_count4_stage.sv
// Directed self-checking bench for count4_stage (MOD=16, MOD=10 and a two-stage cascade).
module tb_count4_stage;
  logic clk, rst;

  logic       a_en, a_load, a_sat, a_clr;
  logic [3:0] a_din, a_q;
  logic       a_tc, a_co, a_ovf;

  logic       b_en, b_load, b_sat, b_clr;
  logic [3:0] b_din, b_q;
  logic       b_tc, b_co, b_ovf;

  logic       c_en;
  logic [3:0] c0_q, c1_q;
  logic       c0_tc, c0_co, c0_ovf, c1_tc, c1_co, c1_ovf;

  int tests  = 0;
  int failed = 0;

  count4_stage u16 (
    .clk(clk), .rst(rst), .en(a_en), .load(a_load), .din(a_din),
    .sat_mode(a_sat), .clr_ovf(a_clr), .q(a_q), .tc(a_tc),
    .carry_out(a_co), .ovf(a_ovf)
  );

  count4_stage #(.MOD(10)) u10 (
    .clk(clk), .rst(rst), .en(b_en), .load(b_load), .din(b_din),
    .sat_mode(b_sat), .clr_ovf(b_clr), .q(b_q), .tc(b_tc),
    .carry_out(b_co), .ovf(b_ovf)
  );

  count4_stage u_lo (
    .clk(clk), .rst(rst), .en(c_en), .load(1'b0), .din(4'h0),
    .sat_mode(1'b0), .clr_ovf(1'b0), .q(c0_q), .tc(c0_tc),
    .carry_out(c0_co), .ovf(c0_ovf)
  );

  count4_stage u_hi (
    .clk(clk), .rst(rst), .en(c0_co), .load(1'b0), .din(4'h0),
    .sat_mode(1'b0), .clr_ovf(1'b0), .q(c1_q), .tc(c1_tc),
    .carry_out(c1_co), .ovf(c1_ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    a_en = 0; a_load = 0; a_sat = 0; a_clr = 0; a_din = '0;
    b_en = 0; b_load = 0; b_sat = 0; b_clr = 0; b_din = '0;
    c_en = 0;
    #12 rst = 1'b0;
    check("reset_q", 8'(a_q), 8'h00);
    check("reset_ovf", 8'(a_ovf), 8'h00);
    check("reset_tc", 8'(a_tc), 8'h00);

    // Wrap at 16
    tick();
    a_load = 1; a_din = 4'd14;
    tick();
    a_load = 0; a_en = 1;
    check("wrap_q14", 8'(a_q), 8'd14);
    check("wrap_tc14", 8'({a_tc, a_co}), 8'b00);
    tick();
    check("wrap_q15", 8'(a_q), 8'd15);
    check("wrap_tc15", 8'({a_tc, a_co}), 8'b11);
    check("wrap_ovf15", 8'(a_ovf), 8'h0);
    tick();
    check("wrap_q0", 8'(a_q), 8'd0);
    check("wrap_ovf0", 8'(a_ovf), 8'h1);
    check("wrap_tc0", 8'({a_tc, a_co}), 8'b00);

    // Load 9 keeps ovf, then async reset mid-cycle
    a_en = 0; a_load = 1; a_din = 4'd9;
    tick();
    a_load = 0;
    check("ld9_q", 8'(a_q), 8'd9);
    check("ld9_ovf", 8'(a_ovf), 8'h1);
    #3 rst = 1'b1;
    #1;
    check("async_rst_q", 8'(a_q), 8'd0);
    check("async_rst_ovf", 8'(a_ovf), 8'h0);
    a_en = 1;
    #2 rst = 1'b0;
    check("rel_q0", 8'(a_q), 8'd0);
    tick();
    check("rel_q1", 8'(a_q), 8'd1);
    tick();
    check("rel_q2", 8'(a_q), 8'd2);

    // Load priority over enable
    a_en = 0; a_load = 1; a_din = 4'd5;
    tick();
    check("ld5_q", 8'(a_q), 8'd5);
    a_en = 1; a_din = 4'd12;
    tick();
    check("ldpri_q", 8'(a_q), 8'd12);
    check("ldpri_ovf", 8'(a_ovf), 8'h0);
    a_load = 0; a_en = 0;
    tick();
    check("hold_q", 8'(a_q), 8'd12);

    // Modulo-10 stage: saturate and ovf clear
    b_load = 1; b_din = 4'd8; b_sat = 1;
    tick();
    b_load = 0; b_en = 1;
    check("sat_q8", 8'(b_q), 8'd8);
    tick();
    check("sat_q9a", 8'(b_q), 8'd9);
    check("sat_tc9", 8'({b_tc, b_co}), 8'b11);
    check("sat_ovf9a", 8'(b_ovf), 8'h0);
    tick();
    check("sat_q9b", 8'(b_q), 8'd9);
    check("sat_ovf9b", 8'(b_ovf), 8'h1);
    tick();
    check("sat_q9c", 8'(b_q), 8'd9);
    b_en = 0; b_clr = 1;
    #0 check("sat_co_en0", 8'({b_tc, b_co}), 8'b10);
    tick();
    check("clr_ovf", 8'(b_ovf), 8'h0);
    check("clr_q", 8'(b_q), 8'd9);
    b_en = 1;
    tick();
    check("set_wins_ovf", 8'(b_ovf), 8'h1);
    check("set_wins_q", 8'(b_q), 8'd9);

    // Modulo-10 stage: out-of-range load in wrap mode
    b_en = 0; b_sat = 0; b_load = 1; b_din = 4'd14;
    tick();
    b_load = 0; b_clr = 0; b_en = 1;
    check("oor_q14", 8'(b_q), 8'd14);
    check("oor_ovf14", 8'(b_ovf), 8'h0);
    check("oor_tc14", 8'(b_tc), 8'h0);
    tick();
    check("oor_q15", 8'(b_q), 8'd15);
    check("oor_tc15", 8'(b_tc), 8'h0);
    check("oor_ovf15", 8'(b_ovf), 8'h0);
    tick();
    check("oor_q0", 8'(b_q), 8'd0);
    check("oor_ovf0", 8'(b_ovf), 8'h1);
    tick();
    check("oor_q1", 8'(b_q), 8'd1);
    b_en = 0;

    // Two-stage cascade, 40 enabled cycles from 0
    check("casc_start", {c1_q, c0_q}, 8'h00);
    c_en = 1;
    for (int i = 0; i < 40; i++) tick();
    c_en = 0;
    check("casc_40", {c1_q, c0_q}, 8'h28);
    check("casc_ovf", 8'({c1_ovf, c0_ovf}), 8'b01);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/count4_stage.md
Name: count4_stage

Overview:
- Registered 4-bit counter stage built around the existing combinational 4-bit incrementer (incrementer4bit).
- Sits directly downstream of the incrementer: it consumes the 5-bit sum and feeds its own register output back as the incrementer input.
- Adds enable, synchronous load, a programmable terminal count, wrap or saturate mode, a cascade carry and a sticky overflow flag.
- Used as the basic timing/sequence counter in the lab designs; carry_out chains stages for wider counts.

Parameters:
- MOD, 16, count modulus. Terminal value is MOD-1. Legal range 2..16.
- RESET_VAL, 0, value of q after reset. Must be below MOD.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  count enable, sampled at the clk rising edge.
- load  input  1  synchronous load, sampled at the clk rising edge.
- din  input  4  load value.
- sat_mode  input  1  0 = wrap at terminal, 1 = hold at terminal.
- clr_ovf  input  1  synchronous clear of ovf.
- q  output  4  registered count value.
- tc  output  1  combinational; 1 when q == MOD-1.
- carry_out  output  1  combinational; en & tc, used to enable the next cascaded stage.
- ovf  output  1  registered, sticky overflow flag.

Behaviour:
- Reset (async, active-high): q = RESET_VAL and ovf = 0 immediately, independent of clk. While rst is high, all inputs are ignored. Deasserting rst mid-count restarts from RESET_VAL on the next edge.
- Priority at each rising edge: load > en > hold.
- load=1: q <= din, regardless of en or sat_mode. ovf is not set by a load.
- load=0, en=1, q != MOD-1 and incrementer carry (s[4]) = 0: q <= s[3:0], i.e. q+1. Latency is one cycle; q is visible the cycle after en is sampled.
- load=0, en=1, q == MOD-1, sat_mode=0: q <= 0 (wrap), and ovf <= 1.
- load=0, en=1, q == MOD-1, sat_mode=1: q holds at MOD-1, and ovf <= 1.
- Out-of-range load (din > MOD-1, only possible when MOD < 16): the value is held and counting continues upward. When the incrementer carry s[4]=1 (q = 15), the counter wraps to 0 in wrap mode and sets ovf. In saturate mode it holds at 15 and sets ovf.
- en=0, load=0: q holds.
- ovf is sticky. clr_ovf=1 clears it at the edge. If a set condition and clr_ovf occur in the same cycle, set wins (ovf = 1).
- tc and carry_out are purely combinational from q and en. With MOD=16, carry_out equals en & incrementer carry s[4].
- No X propagation: every flop has a defined reset value and every input combination has a defined next state.

Decomposition:
- Shared package/header: COUNT_W = 4 and the default MOD and RESET_VAL constants. No typedefs are needed.
- Instantiate incrementer4bit for the +1 datapath.
- One natural sub-module, dff4_ar: a 4-bit D register with asynchronous active-high reset to a parameterized value.
- Next-state mux, terminal compare and ovf flop live in count4_stage itself.

Test Plan:
- Reset: drive rst=1 asynchronously mid-cycle with q=9 -> q=0 and ovf=0 immediately, before the next clk edge. After release with en=1, q increments 0,1,2 on successive edges.
- Wrap: MOD=16, sat_mode=0, en=1 from q=14 -> q goes 15 then 0. tc=1 and carry_out=1 only while q=15. ovf=1 from the wrap edge onward.
- Saturate plus ovf clear: MOD=10, sat_mode=1, en=1 from q=8 -> q goes 9, 9, 9 with ovf=1. Pulse clr_ovf with en=0 -> ovf=0. Pulse clr_ovf with en=1 at q=9 -> ovf stays 1 (set wins).
- Load priority: q=5, load=1, en=1, din=12 -> q=12 next cycle, ovf unchanged. load=0, en=0 -> q holds at 12.
- Out-of-range load: MOD=10, sat_mode=0, load din=14, then en=1 -> q goes 15, then 0 with ovf=1. tc stays 0 throughout.
- Cascade: two stages, stage B en = stage A carry_out, both MOD=16. Run 40 enabled cycles from 0 -> {B,A} = 0x28 (decimal 40).
